uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART.
- Consumes the oversampled `rx_tick` from the rx tick generator and drives that generator's `syn_clr` to realign its phase on every start-bit edge.
- Walks the serial frame (start, 5–8 data bits, optional parity, stop), samples each bit at its centre, and delivers the assembled character with parity, framing and break status to the RX FIFO/LSR logic.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the `rx_in` synchroniser (minimum 2).

Ports:
- clk       input   1  system clock
- rst_n     input   1  asynchronous active-low reset
- en        input   1  receiver enable; level
- rx_in     input   1  raw serial line, idle high, asynchronous
- rx_tick   input   1  one-clk pulse at the oversample rate
- OSM_SEL   input   1  0: 16x oversampling, 1: 13x oversampling
- WLS       input   2  word length: 00=5, 01=6, 10=7, 11=8 bits
- PEN       input   1  parity enable
- EPS       input   1  even parity select
- SP        input   1  stick parity
- syn_clr   output  1  one-clk pulse that clears the tick generator's counter
- rx_data   output  8  received character, LSB-aligned, unused MSBs zero
- rx_valid  output  1  one-clk pulse; `rx_data` and the error flags are valid this cycle
- pe        output  1  parity error, qualified by `rx_valid`
- fe        output  1  framing error, qualified by `rx_valid`
- bi        output  1  break indication, qualified by `rx_valid`
- busy      output  1  high in any state except IDLE

Behaviour:
- Reset: state=IDLE.
  - `syn_clr`, `rx_valid`, `pe`, `fe`, `bi`, `busy` = 0.
  - `rx_data` = 8'h00.
  - Synchroniser flops = 1.
  - Tick counter and bit counter = 0.
- `rx_s` is `rx_in` after SYNC_STAGES flops. All decisions use `rx_s` only.
- Oversampling: OSR = 16 (OSM_SEL=0) or 13 (OSM_SEL=1). MID = 8 or 6 respectively.
- `tcnt` is a 4-bit tick counter that increments only on `rx_tick`.
- Config inputs (WLS/PEN/EPS/SP/OSM_SEL) are captured into shadow registers on the start-edge cycle. Changes mid-frame have no effect until the next frame.
- States:
  - IDLE: when en=1 and `rx_s`=0, assert `syn_clr` for exactly 1 clk, latch config, clear `tcnt`, and go to START.
  - START: when `tcnt` reaches MID on an `rx_tick`, sample `rx_s`.
    - Sample 0: clear `tcnt`, set bit index 0, go to DATA.
    - Sample 1: false start; return to IDLE with no `rx_valid`.
  - DATA: every OSR ticks, sample `rx_s` into shift position `bitidx` (LSB first).
    - After bit WLS+4, go to PARITY if PEN=1, else to STOP.
  - PARITY: sample after OSR ticks.
    - Expected bit: SP=1 → ~EPS; SP=0,EPS=1 → even total ones over data+parity; SP=0,EPS=0 → odd.
    - Mismatch sets the internal `pe`.
  - STOP: sample after OSR ticks. Only the first stop bit is checked; a second stop bit is treated as idle.
    - `fe` = ~sample.
    - `bi` = 1 when every data bit, parity (if enabled) and stop sample are 0.
    - Next clk: `rx_valid`=1 for 1 clk with `rx_data`/`pe`/`fe`/`bi`.
    - If `bi`=1, go to BRK_WAIT; otherwise go to IDLE.
  - BRK_WAIT: stay until `rx_s`=1, then go to IDLE. This prevents a held-low line re-triggering frames.
- A frame with `fe`=1 but `bi`=0 returns to IDLE directly. A still-low line is then treated as a new start edge.
- `rx_valid` latency: exactly 1 clk after the `rx_tick` cycle that samples the stop bit.
- `pe`/`fe`/`bi` hold their values until the next `rx_valid`. Consumers qualify them with `rx_valid`.
- en=0 in any state: synchronous abort to IDLE on the next clk.
  - No `rx_valid`; `tcnt` and the bit counter are cleared.
  - `rx_data` and the flags keep their last values.
- `rx_tick` coinciding with the start-edge cycle is ignored: `tcnt` is cleared that cycle.
- Counter wrap: `tcnt` is cleared on every sample event, so it never exceeds 15.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronous).

Test Plan:
1. 16x, 8N1, send 8'hA5 → one `rx_valid`; `rx_data`=8'hA5, `pe`=`fe`=`bi`=0; one `syn_clr` pulse 2 clk after the falling edge of `rx_in`.
2. 13x, 7E1, send 7'h35 with a correct parity bit, then 7'h35 with a flipped parity bit → first: `rx_data`=8'h35, `pe`=0; second: `pe`=1, `rx_data`=8'h35.
3. 16x, 5N1, send 5'h1F with the stop bit driven low → `rx_data`=8'h1F (MSBs zero), `fe`=1, `bi`=0, then next frame received correctly.
4. Hold `rx_in`=0 for 3 frame times (8N1) → exactly one `rx_valid` with `rx_data`=8'h00, `fe`=1, `bi`=1; no further `rx_valid` until `rx_in` returns high.
5. Low glitch on `rx_in` of 3 ticks (shorter than MID) → `syn_clr` pulses, state returns to IDLE, no `rx_valid`, `busy` low after the START sample.
6. Deassert en during DATA bit 3 → `busy`=0 next clk, no `rx_valid`; re-enable and send 8'h3C → `rx_data`=8'h3C received correctly; assert rst_n=0 mid-frame → all outputs 0 asynchronously.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
`timescale 1ns/1ps
// uart_rx_ctrl: receive-side sequencer for the UART.
// It synchronises the serial line and realigns the external tick generator on
// each start edge. It walks start, 5-8 data bits, optional parity and stop,
// sampling each bit at its centre. It then delivers the character together
// with parity, framing and break status.
module uart_rx_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       rx_in,
  input  logic       rx_tick,
  input  logic       OSM_SEL,
  input  logic [1:0] WLS,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  output logic       syn_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  logic [3:0] tcnt;
  logic [2:0] bitidx;
  logic [7:0] data_sr;
  logic       all_zero;
  logic       pe_int;

  // Frame configuration frozen at the start edge
  logic       osm_q;
  logic [1:0] wls_q;
  logic       pen_q;
  logic       eps_q;
  logic       sp_q;

  logic [3:0] osr_last;
  logic [3:0] mid_last;
  logic [2:0] last_bit;
  logic       par_exp;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign osr_last = osm_q ? 4'd12 : 4'd15;
  assign mid_last = osm_q ? 4'd5 : 4'd7;
  assign last_bit = {1'b0, wls_q} + 3'd4;
  assign par_exp  = sp_q ? ~eps_q : (eps_q ? ^data_sr : ~(^data_sr));

  // Bring the asynchronous line into the clock domain; idle level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  // Frame sequencer with registered outputs; counters restart on every sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      syn_clr  <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
      pe       <= 1'b0;
      fe       <= 1'b0;
      bi       <= 1'b0;
      busy     <= 1'b0;
      tcnt     <= 4'd0;
      bitidx   <= 3'd0;
      data_sr  <= 8'h00;
      all_zero <= 1'b0;
      pe_int   <= 1'b0;
      osm_q    <= 1'b0;
      wls_q    <= 2'b00;
      pen_q    <= 1'b0;
      eps_q    <= 1'b0;
      sp_q     <= 1'b0;
    end else begin
      syn_clr  <= 1'b0;
      rx_valid <= 1'b0;
      if (!en) begin
        state  <= IDLE;
        busy   <= 1'b0;
        tcnt   <= 4'd0;
        bitidx <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              syn_clr  <= 1'b1;
              osm_q    <= OSM_SEL;
              wls_q    <= WLS;
              pen_q    <= PEN;
              eps_q    <= EPS;
              sp_q     <= SP;
              tcnt     <= 4'd0;
              bitidx   <= 3'd0;
              data_sr  <= 8'h00;
              all_zero <= 1'b1;
              pe_int   <= 1'b0;
              busy     <= 1'b1;
              state    <= START;
            end
          end
          START: begin
            if (rx_tick) begin
              if (tcnt == mid_last) begin
                tcnt <= 4'd0;
                if (!rx_s) begin
                  bitidx <= 3'd0;
                  state  <= DATA;
                end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
                end
              end else begin
                tcnt <= tcnt + 4'd1;
              end
            end
          end
          DATA: begin
            if (rx_tick) begin
              if (tcnt == osr_last) begin
                tcnt            <= 4'd0;
                data_sr[bitidx] <= rx_s;
                if (rx_s) begin
                  all_zero <= 1'b0;
                end
                if (bitidx == last_bit) begin
                  state <= pen_q ? PARITY : STOP;
                end else begin
                  bitidx <= bitidx + 3'd1;
                end
              end else begin
                tcnt <= tcnt + 4'd1;
              end
            end
          end
          PARITY: begin
            if (rx_tick) begin
              if (tcnt == osr_last) begin
                tcnt   <= 4'd0;
                pe_int <= (rx_s != par_exp);
                if (rx_s) begin
                  all_zero <= 1'b0;
                end
                state <= STOP;
              end else begin
                tcnt <= tcnt + 4'd1;
              end
            end
          end
          STOP: begin
            if (rx_tick) begin
              if (tcnt == osr_last) begin
                tcnt     <= 4'd0;
                rx_valid <= 1'b1;
                rx_data  <= data_sr;
                pe       <= pe_int;
                fe       <= ~rx_s;
                bi       <= all_zero & ~rx_s;
                if (all_zero && !rx_s) begin
                  state <= BRK_WAIT;
                end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
                end
              end else begin
                tcnt <= tcnt + 4'd1;
              end
            end
          end
          BRK_WAIT: begin
            if (rx_s) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
